// File: rtl/fifo_rd_fwft.sv
// ============================================================================
// Module   : fifo_rd_fwft
// Brief    : FIFO read-side controller with first-word-fall-through output
//            register and valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_fwft #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rwords,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
);

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0]   rbin_q;
    logic [ADDRSIZE:0]   rptr_q;
    logic                rempty_q;
    logic [ADDRSIZE:0]   rwords_q;
    logic [DATASIZE-1:0] dout_q;
    logic                dout_valid_q;

    logic                fetch;
    logic [ADDRSIZE:0]   rbin_d;
    logic [ADDRSIZE:0]   rgray_d;
    logic [ADDRSIZE:0]   wbin;

    // A word moves from memory into the output register whenever the register
    // is free or being drained in this same cycle.
    assign fetch   = ~rempty_q & (~dout_valid_q | dout_ready);
    assign rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
    assign rgray_d = (rbin_d >> 1) ^ rbin_d;
    assign wbin    = gray2bin(rq2_wptr);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            rwords_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rgray_d;
            rempty_q <= (rgray_d == rq2_wptr);
            rwords_q <= wbin - rbin_d;
            if (fetch) begin
                dout_q       <= rdata_mem;
                dout_valid_q <= 1'b1;
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign rwords     = rwords_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_fwft.sv
// ============================================================================
// Module   : tb_fifo_rd_fwft
// Brief    : Directed self-checking bench for fifo_rd_fwft with a behavioural
//            memory and write-pointer model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_fwft;

    logic       rclk;
    logic       rrst_n;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata_mem;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [4:0] rwords;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    logic [7:0] mem [16];
    logic [4:0] wbin;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    assign rq2_wptr  = (wbin >> 1) ^ wbin;
    assign rdata_mem = mem[raddr];

    fifo_rd_fwft #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rq2_wptr   (rq2_wptr),
        .rdata_mem  (rdata_mem),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .rwords     (rwords),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic do_reset();
        @(negedge rclk);
        rrst_n     = 1'b0;
        wbin       = '0;
        dout_ready = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
    endtask

    task automatic test_reset();
        rrst_n     = 1'b1;
        wbin       = '0;
        dout_ready = 1'b0;
        #2 rrst_n = 1'b0;
        #1;
        chk_cnt++; if (rempty !== 1'b1) $display("FAIL reset_rempty: got %b expected 1", rempty); else pass_cnt++;
        chk_cnt++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dout_valid); else pass_cnt++;
        chk_cnt++; if (rptr !== 5'd0) $display("FAIL reset_rptr: got %b expected 00000", rptr); else pass_cnt++;
        chk_cnt++; if (raddr !== 4'd0) $display("FAIL reset_raddr: got %h expected 0", raddr); else pass_cnt++;
        chk_cnt++; if (rwords !== 5'd0) $display("FAIL reset_rwords: got %0d expected 0", rwords); else pass_cnt++;
        chk_cnt++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else pass_cnt++;
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
    endtask

    task automatic test_single();
        do_reset();
        mem[0]     = 8'hA5;
        wbin       = 5'd1;
        dout_ready = 1'b0;
        @(negedge rclk);
        chk_cnt++; if (rempty !== 1'b0) $display("FAIL single_rempty_fall: got %b expected 0", rempty); else pass_cnt++;
        chk_cnt++; if (dout_valid !== 1'b0) $display("FAIL single_valid_early: got %b expected 0", dout_valid); else pass_cnt++;
        chk_cnt++; if (rwords !== 5'd1) $display("FAIL single_rwords: got %0d expected 1", rwords); else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            chk_cnt++;
            if (dout !== 8'hA5 || dout_valid !== 1'b1 || rptr !== 5'b00001 || rempty !== 1'b1)
                $display("FAIL single_hold cyc %0d: got dout=%h v=%b rptr=%b e=%b expected A5 1 00001 1",
                         c, dout, dout_valid, rptr, rempty);
            else pass_cnt++;
        end
        dout_ready = 1'b1;
        @(negedge rclk);
        chk_cnt++; if (dout_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", dout_valid); else pass_cnt++;
        dout_ready = 1'b0;
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        wbin       = 5'd16;
        dout_ready = 1'b1;
        @(negedge rclk);
        chk_cnt++; if (rempty !== 1'b0 || dout_valid !== 1'b0)
            $display("FAIL burst_start: got e=%b v=%b expected 0 0", rempty, dout_valid); else pass_cnt++;
        chk_cnt++; if (rwords !== 5'd16) $display("FAIL burst_rwords_full: got %0d expected 16", rwords); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            @(negedge rclk);
            chk_cnt++;
            if (dout_valid !== 1'b1 || dout !== 8'(i) || rwords !== 5'(15 - i))
                $display("FAIL burst_beat %0d: got v=%b dout=%h rwords=%0d expected 1 %h %0d",
                         i, dout_valid, dout, rwords, 8'(i), 15 - i);
            else pass_cnt++;
        end
        chk_cnt++; if (rempty !== 1'b1) $display("FAIL burst_empty_end: got %b expected 1", rempty); else pass_cnt++;
        @(negedge rclk);
        chk_cnt++; if (dout_valid !== 1'b0) $display("FAIL burst_valid_end: got %b expected 0", dout_valid); else pass_cnt++;
        dout_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int written  = 0;
        int accepted = 0;
        int cycles   = 0;
        bit stall    = 1'b0;
        logic [7:0] stall_data = '0;
        do_reset();
        while (accepted < 100 && cycles < 3000) begin
            if (stall) begin
                chk_cnt++;
                if (dout_valid !== 1'b1 || dout !== stall_data)
                    $display("FAIL bp_stall_stable word %0d: got v=%b dout=%h expected 1 %h",
                             accepted, dout_valid, dout, stall_data);
                else pass_cnt++;
            end
            dout_ready = ($urandom_range(0, 2) != 0);
            stall      = dout_valid && !dout_ready;
            stall_data = dout;
            if (dout_valid && dout_ready) begin
                chk_cnt++;
                if (dout !== 8'(accepted * 7 + 3))
                    $display("FAIL bp_data word %0d: got %h expected %h", accepted, dout, 8'(accepted * 7 + 3));
                else pass_cnt++;
                accepted++;
            end
            if (written < 100 && (written - accepted) < 16) begin
                mem[written % 16] = 8'(written * 7 + 3);
                written++;
                wbin = 5'(written);
            end
            @(negedge rclk);
            cycles++;
        end
        chk_cnt++; if (accepted != 100) $display("FAIL bp_timeout: got %0d words expected 100", accepted); else pass_cnt++;
        dout_ready = 1'b0;
        @(negedge rclk);
        chk_cnt++; if (dout_valid !== 1'b0 || rempty !== 1'b1)
            $display("FAIL bp_no_extra: got v=%b e=%b expected 0 1", dout_valid, rempty); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int written  = 0;
        int accepted = 0;
        int cycles   = 0;
        int bad_step = 0;
        bit wrap_seen = 1'b0;
        logic [4:0] prev_rptr;
        do_reset();
        prev_rptr  = rptr;
        dout_ready = 1'b1;
        while (accepted < 40 && cycles < 500) begin
            if ($countones(rptr ^ prev_rptr) > 1) bad_step++;
            if (prev_rptr == 5'b10000 && rptr == 5'b00000) wrap_seen = 1'b1;
            prev_rptr = rptr;
            if (dout_valid) begin
                chk_cnt++;
                if (dout !== 8'(8'hC0 + accepted))
                    $display("FAIL wrap_data word %0d: got %h expected %h", accepted, dout, 8'(8'hC0 + accepted));
                else pass_cnt++;
                accepted++;
            end
            if (written < 40 && (written - accepted) < 16) begin
                mem[written % 16] = 8'(8'hC0 + written);
                written++;
                wbin = 5'(written);
            end
            @(negedge rclk);
            cycles++;
        end
        chk_cnt++; if (accepted != 40) $display("FAIL wrap_timeout: got %0d words expected 40", accepted); else pass_cnt++;
        chk_cnt++; if (bad_step != 0) $display("FAIL wrap_gray_step: got %0d multi-bit steps expected 0", bad_step); else pass_cnt++;
        chk_cnt++; if (!wrap_seen) $display("FAIL wrap_rptr_wrap: got no 10000->00000 step expected one"); else pass_cnt++;
        chk_cnt++; if (raddr !== 4'd8) $display("FAIL wrap_raddr_end: got %0d expected 8", raddr); else pass_cnt++;
        dout_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int cycles = 0;
        int got    = 0;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
        wbin       = 5'd16;
        dout_ready = 1'b1;
        while (!(dout_valid === 1'b1 && dout === 8'h47) && cycles < 40) begin
            @(negedge rclk);
            cycles++;
        end
        chk_cnt++; if (cycles >= 40) $display("FAIL arst_reach_word7: got dout=%h expected 47", dout); else pass_cnt++;
        #2;
        rrst_n = 1'b0;
        wbin   = '0;
        #1;
        chk_cnt++; if (dout_valid !== 1'b0 || rptr !== 5'd0 || raddr !== 4'd0)
            $display("FAIL arst_immediate: got v=%b rptr=%b raddr=%h expected 0 0 0", dout_valid, rptr, raddr);
        else pass_cnt++;
        chk_cnt++; if (rempty !== 1'b1 || dout !== 8'h00)
            $display("FAIL arst_state: got e=%b dout=%h expected 1 00", rempty, dout); else pass_cnt++;
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 4; i++) mem[i] = 8'(8'h90 + i);
        wbin   = 5'd4;
        cycles = 0;
        while (got < 4 && cycles < 20) begin
            @(negedge rclk);
            cycles++;
            if (dout_valid) begin
                chk_cnt++;
                if (dout !== 8'(8'h90 + got))
                    $display("FAIL arst_refill word %0d: got %h expected %h", got, dout, 8'(8'h90 + got));
                else pass_cnt++;
                got++;
            end
        end
        chk_cnt++; if (got != 4) $display("FAIL arst_refill_count: got %0d expected 4", got); else pass_cnt++;
        dout_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
